// File: rtl/conv3x3_mac_acc.sv
// ---------------------------------------------------------------------------
// conv3x3_mac_acc
//
// Multi-channel 3x3 convolution MAC for one output channel. Each input beat
// carries one 3x3 activation window and its matching 3x3 signed weight set for
// one input channel. Beats are accumulated over NUM_IC channels. After the last
// channel the bias is added, and the sum is requantised by a rounding
// arithmetic right shift followed by signed saturation to OUTW bits.
//
// Pipeline: stage 1 = nine products, stage 2 = adder tree, stage 3 =
// accumulate / bias / requantise / output register. oOutValid rises three
// cycles after the last-channel beat is sampled. Full throughput, no bubbles.
//
// Ports:
//   iClk            clock
//   iRsn            asynchronous active-low reset
//   iClear          synchronous abort, discards the partial pixel and beats
//                   in flight; wins over a simultaneous iInValid
//   iInValid        window/weight beat valid
//   iWindowInRow1-3 activation rows, a[r][0] at MSBs, a[r][2] at LSBs
//   iWeight         w00 at [WI-1:0] ascending to w22 at the MSBs
//   iBias           signed bias, sampled on the last-channel beat only
//   oOutValid       one-cycle result strobe
//   oOutData        signed requantised result (holds between strobes)
//   oSatFlag        high with oOutValid when clamping occurred
//   oChIdx          channel index expected on the next beat
//
// Optional build macro: CONV3X3_MAC_ACC_RELU_EN
//   When defined, negative saturated results are forced to zero. oSatFlag
//   still reports only upper/lower clamping. Latency is unchanged.
// ---------------------------------------------------------------------------
module conv3x3_mac_acc #(
    parameter int WI     = 8,
    parameter int NUM_IC = 4,
    parameter int BW     = 32,
    parameter int ACCW   = 32,
    parameter int SHIFT  = 0,
    parameter int OUTW   = 16
) (
    input  logic                  iClk,
    input  logic                  iRsn,
    input  logic                  iClear,
    input  logic                  iInValid,
    input  logic [3*WI-1:0]       iWindowInRow1,
    input  logic [3*WI-1:0]       iWindowInRow2,
    input  logic [3*WI-1:0]       iWindowInRow3,
    input  logic [9*WI-1:0]       iWeight,
    input  logic [BW-1:0]         iBias,
    output logic                  oOutValid,
    output logic [OUTW-1:0]       oOutData,
    output logic                  oSatFlag,
    output logic [((NUM_IC > 1) ? $clog2(NUM_IC) : 1)-1:0] oChIdx
);

    localparam int CIW = (NUM_IC > 1) ? $clog2(NUM_IC) : 1;
    localparam int PW  = 2 * WI;

    // ------------------------------------------------------------------
    // Channel counter
    // ------------------------------------------------------------------
    logic [CIW-1:0] ch_idx_reg;
    logic           is_last;
    logic           beat_ok;

    assign is_last = (ch_idx_reg == CIW'(NUM_IC - 1));
    assign beat_ok = iInValid & ~iClear;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            ch_idx_reg <= '0;
        end else if (iClear) begin
            ch_idx_reg <= '0;
        end else if (iInValid) begin
            ch_idx_reg <= is_last ? '0 : ch_idx_reg + CIW'(1);
        end
    end

    assign oChIdx = ch_idx_reg;

    // ------------------------------------------------------------------
    // Stage 1: nine signed products
    // ------------------------------------------------------------------
    logic [9*WI-1:0] win_flat;
    logic [9*PW-1:0] prod_flat;

    // Tap k = 3*row + col; a00 ends up at the MSBs of win_flat.
    assign win_flat = {iWindowInRow1, iWindowInRow2, iWindowInRow3};

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        logic signed [WI-1:0] a_tap;
        logic signed [WI-1:0] w_tap;
        logic signed [PW-1:0] prod_reg;

        assign a_tap = win_flat[(8-gi)*WI +: WI];
        assign w_tap = iWeight[gi*WI +: WI];

        always_ff @(posedge iClk or negedge iRsn) begin
            if (!iRsn) begin
                prod_reg <= '0;
            end else if (beat_ok) begin
                prod_reg <= PW'(a_tap) * PW'(w_tap);
            end
        end

        assign prod_flat[gi*PW +: PW] = prod_reg;
    end

    logic                 v1_reg;
    logic                 last1_reg;
    logic signed [BW-1:0] bias1_reg;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            v1_reg    <= 1'b0;
            last1_reg <= 1'b0;
            bias1_reg <= '0;
        end else begin
            v1_reg    <= beat_ok;
            last1_reg <= beat_ok & is_last;
            if (beat_ok && is_last) begin
                bias1_reg <= iBias;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sign-extend and sum the nine products
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < 9; k++) begin
            sum_next = sum_next + ACCW'($signed(prod_flat[k*PW +: PW]));
        end
    end

    logic                   v2_reg;
    logic                   last2_reg;
    logic signed [ACCW-1:0] sum2_reg;
    logic signed [BW-1:0]   bias2_reg;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            v2_reg    <= 1'b0;
            last2_reg <= 1'b0;
            sum2_reg  <= '0;
            bias2_reg <= '0;
        end else begin
            v2_reg    <= v1_reg & ~iClear;
            last2_reg <= last1_reg & ~iClear;
            sum2_reg  <= sum_next;
            bias2_reg <= bias1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: accumulate, add bias, requantise
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] acc_reg;
    logic signed [ACCW-1:0] total_next;
    logic signed [ACCW:0]   total_ext;
    logic signed [ACCW:0]   rnd_next;

    assign total_next = acc_reg + sum2_reg + ACCW'(bias2_reg);
    // One guard bit so the rounding offset cannot wrap before the shift.
    assign total_ext  = (ACCW+1)'(total_next);

    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACCW:0] RND_OFS = (ACCW+1)'(1) <<< (SHIFT - 1);
        assign rnd_next = (total_ext + RND_OFS) >>> SHIFT;
    end else begin : g_noround
        assign rnd_next = total_ext;
    end

    logic            ovf_pos;
    logic            ovf_neg;
    logic [OUTW-1:0] res_next;

    // The value fits in OUTW bits iff every bit above OUTW-2 matches the sign.
    assign ovf_pos = ~rnd_next[ACCW] &  (|rnd_next[ACCW-1:OUTW-1]);
    assign ovf_neg =  rnd_next[ACCW] & ~(&rnd_next[ACCW-1:OUTW-1]);

    always_comb begin
        res_next = rnd_next[OUTW-1:0];
        if (ovf_pos) begin
            res_next = {1'b0, {(OUTW-1){1'b1}}};
        end else if (ovf_neg) begin
            res_next = {1'b1, {(OUTW-1){1'b0}}};
        end
`ifdef CONV3X3_MAC_ACC_RELU_EN
        if (res_next[OUTW-1]) begin
            res_next = '0;
        end
`else
`endif
    end

    logic            out_valid_reg;
    logic [OUTW-1:0] out_data_reg;
    logic            sat_flag_reg;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            sat_flag_reg  <= 1'b0;
        end else if (iClear) begin
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            sat_flag_reg  <= 1'b0;
            if (v2_reg) begin
                if (last2_reg) begin
                    // Clearing here lets the next pixel start the very next cycle.
                    acc_reg       <= '0;
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= res_next;
                    sat_flag_reg  <= ovf_pos | ovf_neg;
                end else begin
                    acc_reg <= acc_reg + sum2_reg;
                end
            end
        end
    end

    assign oOutValid = out_valid_reg;
    assign oOutData  = out_data_reg;
    assign oSatFlag  = sat_flag_reg;

endmodule

// File: tb/tb_conv3x3_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_mac_acc
//
// Three instances share clock, reset and data buses; each has its own valid:
//   u_a : NUM_IC=1, SHIFT=0, OUTW=8   (basic MAC, saturation, back-to-back)
//   u_b : NUM_IC=3, SHIFT=0, OUTW=16  (multi-channel with a gap, oChIdx)
//   u_c : NUM_IC=4, SHIFT=2, OUTW=16  (rounding, random pixels, clear, reset)
// Each instance has a queue of expected results (value, flag, cycle); a
// monitor compares every oOutValid strobe against the head of its queue.
// ---------------------------------------------------------------------------
module tb_conv3x3_mac_acc;

    logic        clk = 1'b0;
    logic        rsn = 1'b0;
    logic        clr = 1'b0;
    logic        vld_a = 1'b0;
    logic        vld_b = 1'b0;
    logic        vld_c = 1'b0;
    logic [23:0] row1 = '0;
    logic [23:0] row2 = '0;
    logic [23:0] row3 = '0;
    logic [71:0] wgt  = '0;
    logic [31:0] bias = '0;

    logic              va, vb, vc;
    logic signed [7:0] da;
    logic signed [15:0] db, dc;
    logic              sa, sb, sc;
    logic [0:0]        ch_a;
    logic [1:0]        ch_b, ch_c;

    always #5 clk = ~clk;

    conv3x3_mac_acc #(.WI(8), .NUM_IC(1), .BW(32), .ACCW(32), .SHIFT(0), .OUTW(8)) u_a (
        .iClk(clk), .iRsn(rsn), .iClear(clr), .iInValid(vld_a),
        .iWindowInRow1(row1), .iWindowInRow2(row2), .iWindowInRow3(row3),
        .iWeight(wgt), .iBias(bias),
        .oOutValid(va), .oOutData(da), .oSatFlag(sa), .oChIdx(ch_a)
    );

    conv3x3_mac_acc #(.WI(8), .NUM_IC(3), .BW(32), .ACCW(32), .SHIFT(0), .OUTW(16)) u_b (
        .iClk(clk), .iRsn(rsn), .iClear(clr), .iInValid(vld_b),
        .iWindowInRow1(row1), .iWindowInRow2(row2), .iWindowInRow3(row3),
        .iWeight(wgt), .iBias(bias),
        .oOutValid(vb), .oOutData(db), .oSatFlag(sb), .oChIdx(ch_b)
    );

    conv3x3_mac_acc #(.WI(8), .NUM_IC(4), .BW(32), .ACCW(32), .SHIFT(2), .OUTW(16)) u_c (
        .iClk(clk), .iRsn(rsn), .iClear(clr), .iInValid(vld_c),
        .iWindowInRow1(row1), .iWindowInRow2(row2), .iWindowInRow3(row3),
        .iWeight(wgt), .iBias(bias),
        .oOutValid(vc), .oOutData(dc), .oSatFlag(sc), .oChIdx(ch_c)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    typedef struct {
        longint d;
        bit     s;
        int     c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;
    int   cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (va === 1'b1) begin
            if (q_a.size() == 0) check("a_unexpected_out", 1, 0);
            else begin
                ea = q_a.pop_front();
                $display("a: out=%0d sat=%0d cyc=%0d", da, sa, cyc);
                check("a_data", da, ea.d);
                check("a_sat", sa, ea.s);
                check("a_latency", cyc, ea.c);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (vb === 1'b1) begin
            if (q_b.size() == 0) check("b_unexpected_out", 1, 0);
            else begin
                eb = q_b.pop_front();
                $display("b: out=%0d sat=%0d cyc=%0d", db, sb, cyc);
                check("b_data", db, eb.d);
                check("b_sat", sb, eb.s);
                check("b_latency", cyc, eb.c);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (vc === 1'b1) begin
            if (q_c.size() == 0) check("c_unexpected_out", 1, 0);
            else begin
                ec = q_c.pop_front();
                $display("c: out=%0d sat=%0d cyc=%0d", dc, sc, cyc);
                check("c_data", dc, ec.d);
                check("c_sat", sc, ec.s);
                check("c_latency", cyc, ec.c);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic signed [7:0] a_arr [9];
    logic signed [7:0] w_arr [9];

    task automatic fill(input int a, input int w);
        for (int k = 0; k < 9; k++) begin
            a_arr[k] = 8'(a);
            w_arr[k] = 8'(w);
        end
    endtask

    task automatic rand_fill();
        for (int k = 0; k < 9; k++) begin
            a_arr[k] = 8'(int'($urandom_range(0, 127)) - 64);
            w_arr[k] = 8'(int'($urandom_range(0, 127)) - 64);
        end
    endtask

    function automatic longint dot9();
        longint s = 0;
        for (int k = 0; k < 9; k++) s += longint'(a_arr[k]) * longint'(w_arr[k]);
        return s;
    endfunction

    // Reference requantisation: round half up, arithmetic shift, clamp.
    function automatic longint rq(input longint t, input int sh, input int ow,
                                  output bit s);
        longint r, hi, lo;
        r  = (sh > 0) ? ((t + (64'sd1 <<< (sh - 1))) >>> sh) : t;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -(64'sd1 <<< (ow - 1));
        s  = 1'b0;
        if (r > hi) begin r = hi; s = 1'b1; end
        if (r < lo) begin r = lo; s = 1'b1; end
`ifdef CONV3X3_MAC_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    // Drive one beat at the falling edge; it is sampled at the next rising edge.
    task automatic beat(input int dut, input int exp_ch, input int b);
        logic [71:0] win;
        @(negedge clk);
        if (exp_ch >= 0) begin
            case (dut)
                0: check("a_ch_idx", ch_a, exp_ch);
                1: check("b_ch_idx", ch_b, exp_ch);
                default: check("c_ch_idx", ch_c, exp_ch);
            endcase
        end
        win = '0;
        for (int k = 0; k < 9; k++) begin
            win[(8-k)*8 +: 8] = a_arr[k];
            wgt[k*8 +: 8]     = w_arr[k];
        end
        row1  = win[71:48];
        row2  = win[47:24];
        row3  = win[23:0];
        bias  = 32'(b);
        vld_a = (dut == 0);
        vld_b = (dut == 1);
        vld_c = (dut == 2);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld_a = 1'b0;
            vld_b = 1'b0;
            vld_c = 1'b0;
        end
    endtask

    // Called right after the last beat is driven: result is due on the
    // third rising edge, counting the edge that samples the beat.
    task automatic push(input int dut, input longint d, input bit s);
        exp_t e;
        e.d = d;
        e.s = s;
        e.c = cyc + 3;
        case (dut)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_valid"}, va, 0);
        check({tag, "_a_data"}, da, 0);
        check({tag, "_a_sat"}, sa, 0);
        check({tag, "_a_ch"}, ch_a, 0);
        check({tag, "_b_valid"}, vb, 0);
        check({tag, "_b_ch"}, ch_b, 0);
        check({tag, "_c_valid"}, vc, 0);
        check({tag, "_c_data"}, dc, 0);
        check({tag, "_c_sat"}, sc, 0);
        check({tag, "_c_ch"}, ch_c, 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        longint t;
        longint r;
        bit     s;
        int     bb;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rsn = 1'b1;

        // u_a: 9*1*2+5 = 23; 9*127*127 clamps to 127; 9*(-128)*127 clamps to -128.
        fill(1, 2);
        beat(0, 0, 5);
        push(0, 23, 1'b0);
        fill(127, 127);
        beat(0, 0, 0);
        push(0, 127, 1'b1);
        fill(-128, 127);
        beat(0, 0, 0);
`ifdef CONV3X3_MAC_ACC_RELU_EN
        push(0, 0, 1'b1);
`else
        push(0, -128, 1'b1);
`endif
        idle(6);

        // u_b: channels give 9, 18, 27; bias -4 -> 50. Junk bias on early beats.
        fill(1, 1);
        beat(1, 0, 77);
        fill(1, 2);
        beat(1, 1, -9);
        idle(1);
        fill(1, 3);
        beat(1, 2, -4);
        push(1, 50, 1'b0);
        idle(1);
        check("b_ch_wrap", ch_b, 0);
        idle(5);

        // u_c rounding (SHIFT=2), three back-to-back pixels:
        //   sum 6 -> 2, sum -6 -> -1, sum 5 -> 1.
        fill(1, 0); w_arr[0] = 8'sd6;
        beat(2, 0, 0);
        fill(0, 0);
        beat(2, 1, 0);
        beat(2, 2, 0);
        beat(2, 3, 0);
        push(2, 2, 1'b0);
        beat(2, 0, 0);
        beat(2, 1, 0);
        beat(2, 2, 0);
        beat(2, 3, -6);
        push(2, -1, 1'b0);
        beat(2, 0, 0);
        beat(2, 1, 0);
        fill(1, 0); w_arr[0] = 8'sd3;
        beat(2, 2, 0);
        fill(0, 0);
        beat(2, 3, 2);
        push(2, 1, 1'b0);
        idle(6);

        // u_c: 20 back-to-back random beats -> 5 pixels.
        for (int p = 0; p < 5; p++) begin
            t = 0;
            for (int c = 0; c < 4; c++) begin
                rand_fill();
                t += dot9();
                bb = int'($urandom_range(0, 4000)) - 2000;
                beat(2, c, bb);
                if (c == 3) begin
                    r = rq(t + longint'(bb), 2, 16, s);
                    push(2, r, s);
                end
            end
        end
        idle(6);

        // u_c: two beats, then iClear (with a colliding beat), then a fresh pixel.
        rand_fill(); beat(2, 0, 11);
        rand_fill(); beat(2, 1, 22);
        @(negedge clk);
        clr   = 1'b1;
        vld_c = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        vld_c = 1'b0;
        check("c_ch_after_clear", ch_c, 0);
        t = 0;
        for (int c = 0; c < 4; c++) begin
            rand_fill();
            t += dot9();
            bb = int'($urandom_range(0, 400)) - 200;
            beat(2, c, bb);
            if (c == 3) begin
                r = rq(t + longint'(bb), 2, 16, s);
                push(2, r, s);
            end
        end
        idle(6);

        // u_c: two beats, asynchronous reset mid-pixel, then a fresh pixel.
        rand_fill(); beat(2, 0, 33);
        rand_fill(); beat(2, 1, 44);
        @(negedge clk);
        vld_c = 1'b0;
        rsn   = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        rsn = 1'b1;
        t = 0;
        for (int c = 0; c < 4; c++) begin
            rand_fill();
            t += dot9();
            bb = int'($urandom_range(0, 400)) - 200;
            beat(2, c, bb);
            if (c == 3) begin
                r = rq(t + longint'(bb), 2, 16, s);
                push(2, r, s);
            end
        end
        idle(8);

        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);
        check("c_pending", q_c.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv3x3_mac_acc.md
Name: conv3x3_mac_acc

Overview:
Parametrised successor to the single-channel 3x3 convolution kernel. Accepts one 3x3 window and its matching 3x3 weight set per input channel per beat, and accumulates over NUM_IC input channels. After the last channel it adds the bias, then applies rounding right-shift requantisation with signed saturation. Sits between the line-buffer/window generator and the output feature-map writer; one instance per output channel.

Parameters:
WI, 8, signed activation and weight width
NUM_IC, 4, input channels accumulated per output pixel (>=1)
BW, 32, bias width (<= ACCW)
ACCW, 32, accumulator width; must be >= 2*WI+4+clog2(NUM_IC)+1
SHIFT, 0, requantisation arithmetic right shift (0..ACCW-2)
OUTW, 16, signed output width (<= ACCW)

Ports:
iClk  in  1  clock
iRsn  in  1  asynchronous active-low reset
iClear  in  1  synchronous abort; discards the partial pixel
iInValid  in  1  window/weight beat valid
iWindowInRow1  in  3*WI  top row; a00 at MSBs, a02 at LSBs
iWindowInRow2  in  3*WI  middle row, same packing
iWindowInRow3  in  3*WI  bottom row, same packing
iWeight  in  9*WI  signed; w00 at [WI-1:0], ascending to w22 at MSBs
iBias  in  BW  signed bias; sampled on the last-channel beat only
oOutValid  out  1  one-cycle result strobe
oOutData  out  OUTW  signed requantised result
oSatFlag  out  1  high with oOutValid when saturation occurred
oChIdx  out  clog2(NUM_IC) (min 1)  channel index expected on next beat

Behaviour:
- Reset (iRsn=0, async): oOutValid=0, oOutData=0, oSatFlag=0, oChIdx=0. Accumulator, pipeline valids and last flags cleared. Reset takes effect mid-pixel with no residue.
- Channel counter oChIdx: increments on each iInValid beat; wraps NUM_IC-1 -> 0. A beat with oChIdx==NUM_IC-1 is the "last" beat. For NUM_IC=1, every beat is last.
- Stage 1 (registered): nine signed WI x WI products (2*WI bits), plus valid, last and bias (bias captured only on last).
- Stage 2 (registered): sign-extend the products to ACCW and sum all nine; valid/last/bias forwarded.
- Stage 3 (registered):
  - v2 & !last2: acc <= acc + s2.
  - v2 & last2: t = acc + s2 + sext(bias); acc <= 0; result and flags are produced as below.
- Requantisation:
  - If SHIFT>0: r = (t + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic).
  - If SHIFT=0: r = t.
  - Saturate r to [-2^(OUTW-1), 2^(OUTW-1)-1]. oSatFlag=1 iff clamping occurred.
- Outputs:
  - On the last beat's result, oOutValid=1, oOutData=sat(r).
  - Otherwise oOutValid=0, oOutData holds its last value, oSatFlag=0.
- Latency: oOutValid asserts exactly 3 cycles after the last-channel beat is sampled.
- Throughput: 1 beat/cycle with no bubbles. Consecutive pixels may be back-to-back; acc clearing on last2 makes the next pixel start from 0 in the same cycle.
- Gaps: iInValid may deassert between channels; acc and oChIdx hold.
- iClear=1: oChIdx<=0, acc<=0, all stage valids <=0. Beats in flight are dropped; oOutValid=0 next cycle. iClear wins over a simultaneous iInValid, whose beat is discarded.
- Accumulator overflow beyond ACCW wraps (two's complement). Excluded by the ACCW sizing rule.

Optional Feature:
Macro CONV3X3_MAC_ACC_RELU_EN.
- Defined: after saturation, negative results are forced to 0. oSatFlag reflects only upper/lower clamping, not ReLU zeroing.
- Undefined: signed result passes unchanged. Latency is identical either way.

Test Plan:
- NUM_IC=1, SHIFT=0: all a=1, all w=2, bias=5, one beat -> oOutValid 3 cycles later, oOutData=23, oSatFlag=0.
- NUM_IC=3: beats with a=1 and w=1, 2, 3 per channel, bias=-4, then 1 idle cycle between channels 1 and 2 -> single result 50, 3 cycles after the third beat; oChIdx sequence 0,1,2,0.
- SHIFT=2: pixel sum 6 -> 2; sum -6 -> -1; sum 5 -> 1 (rounding check).
- OUTW=8, NUM_IC=1: a=127, w=127 at all taps, bias=0 -> oOutData=127, oSatFlag=1. All a=-128, w=127 -> -128, oSatFlag=1. With RELU_EN, the second case gives 0 and oSatFlag=1.
- NUM_IC=4, 20 back-to-back beats of random data -> 5 results on consecutive-pixel cadence, each matching the reference model; no inter-pixel leakage.
- Two channel beats of a NUM_IC=4 pixel, then iClear pulse, then 4 fresh beats -> exactly one output, equal to the fresh pixel only. Repeat with iRsn asserted mid-pixel instead of iClear -> same result and all outputs 0 during reset.
